// File: rtl/block_transfer_seq.sv
// block_transfer_seq
//   Multi-register load/store sequencer (LDM/STM style). Walks a 16-bit
//   register list in ascending index order. Each selected register becomes
//   one word access on the data-memory port.
//     store : RF read port -> mem write
//     load  : mem read     -> RF write port
//   The core stalls while busy_o is high. done_o pulses for one cycle when
//   the sequence completes.
//
// Optional feature (macro BLOCK_TRANSFER_WB_EN):
//   Base-register writeback. It adds the writeback_i and base_reg_i ports.
//   After the last transfer the final address is written to base_reg_i.
//   The writeback is skipped when a load also targets base_reg_i.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start_i/is_load_i/reg_list_i/base_addr_i   command, sampled in IDLE
//   rf_read_addr_o/rf_read_data_i              RF read port (store data)
//   rf_write_addr_o/_data_o/_enable_o          RF write port
//   mem_req_o/we_o/addr_o/wdata_o, mem_rdata_i/mem_ack_i   data-memory port
//   busy_o, done_o                             status
module block_transfer_seq #(
  parameter int N      = 32,
  parameter int STRIDE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic         is_load_i,
  input  logic [15:0]  reg_list_i,
  input  logic [N-1:0] base_addr_i,
  output logic [3:0]   rf_read_addr_o,
  input  logic [N-1:0] rf_read_data_i,
  output logic [3:0]   rf_write_addr_o,
  output logic [N-1:0] rf_write_data_o,
  output logic         rf_write_enable_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [N-1:0] mem_addr_o,
  output logic [N-1:0] mem_wdata_o,
  input  logic [N-1:0] mem_rdata_i,
  input  logic         mem_ack_i,
  output logic         busy_o,
`ifdef BLOCK_TRANSFER_WB_EN
  input  logic         writeback_i,
  input  logic [3:0]   base_reg_i,
`endif
  output logic         done_o
);

`ifdef BLOCK_TRANSFER_WB_EN
  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
`endif

  state_t         state_q, state_d;
  logic [15:0]    mask_q, mask_d;
  logic [N-1:0]   addr_q, addr_d;
  logic           load_q, load_d;
`ifdef BLOCK_TRANSFER_WB_EN
  logic           wb_q, wb_d;
  logic [3:0]     breg_q, breg_d;
`endif

  logic [3:0]     cur;
  logic [15:0]    mask_next;

  // Lowest set bit of the remaining mask, giving ascending register order.
  always_comb begin
    cur = '0;
    for (int k = 15; k >= 0; k--) begin
      if (mask_q[k]) cur = 4'(k);
    end
  end

  // Clearing the lowest set bit is the same as clearing bit 'cur'.
  assign mask_next = mask_q & (mask_q - 16'd1);

  logic [3:0]   rf_raddr_c, rf_waddr_c;
  logic [N-1:0] rf_wdata_c, mem_addr_c, mem_wdata_c;
  logic         rf_we_c, mem_req_c, mem_we_c, busy_c, done_c;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    addr_d      = addr_q;
    load_d      = load_q;
`ifdef BLOCK_TRANSFER_WB_EN
    wb_d        = wb_q;
    breg_d      = breg_q;
`endif
    rf_raddr_c  = '0;
    rf_waddr_c  = '0;
    rf_wdata_c  = '0;
    rf_we_c     = 1'b0;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    busy_c      = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d = reg_list_i;
          addr_d = base_addr_i;
          load_d = is_load_i;
`ifdef BLOCK_TRANSFER_WB_EN
          // A load that also targets the base register keeps the loaded value.
          wb_d   = writeback_i & ~(is_load_i & reg_list_i[base_reg_i]);
          breg_d = base_reg_i;
          if (reg_list_i != 16'd0)
            state_d = XFER;
          else
            state_d = wb_d ? WB : DONE;
`else
          state_d = (reg_list_i != 16'd0) ? XFER : DONE;
`endif
        end
      end

      XFER: begin
        busy_c      = 1'b1;
        mem_req_c   = 1'b1;
        mem_we_c    = ~load_q;
        mem_addr_c  = addr_q;
        rf_raddr_c  = cur;
        mem_wdata_c = rf_read_data_i;
        if (mem_ack_i) begin
          if (load_q) begin
            rf_we_c    = 1'b1;
            rf_waddr_c = cur;
            rf_wdata_c = mem_rdata_i;
          end
          mask_d = mask_next;
          addr_d = addr_q + N'(STRIDE);
          if (mask_next == 16'd0) begin
`ifdef BLOCK_TRANSFER_WB_EN
            state_d = wb_q ? WB : DONE;
`else
            state_d = DONE;
`endif
          end
        end
      end

`ifdef BLOCK_TRANSFER_WB_EN
      WB: begin
        // addr_q has advanced once per transfer, so it holds the final address.
        busy_c     = 1'b1;
        rf_we_c    = 1'b1;
        rf_waddr_c = breg_q;
        rf_wdata_c = addr_q;
        state_d    = DONE;
      end
`endif

      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low during reset so that a reset arriving on an
  // ack cycle cannot cause an RF write or a memory handshake.
  always_comb begin
    rf_read_addr_o    = rst ? '0   : rf_raddr_c;
    rf_write_addr_o   = rst ? '0   : rf_waddr_c;
    rf_write_data_o   = rst ? '0   : rf_wdata_c;
    rf_write_enable_o = rst ? 1'b0 : rf_we_c;
    mem_req_o         = rst ? 1'b0 : mem_req_c;
    mem_we_o          = rst ? 1'b0 : mem_we_c;
    mem_addr_o        = rst ? '0   : mem_addr_c;
    mem_wdata_o       = rst ? '0   : mem_wdata_c;
    busy_o            = rst ? 1'b0 : busy_c;
    done_o            = rst ? 1'b0 : done_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      load_q  <= 1'b0;
`ifdef BLOCK_TRANSFER_WB_EN
      wb_q    <= 1'b0;
      breg_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      load_q  <= load_d;
`ifdef BLOCK_TRANSFER_WB_EN
      wb_q    <= wb_d;
      breg_q  <= breg_d;
`endif
    end
  end

endmodule

// File: doc/block_transfer_seq.md
Name: block_transfer_seq

Overview:
- Multi-register load/store sequencer; this is the initiator side of the 16-entry register file port pair.
- Walks a 16-bit register list. Each selected register becomes one word access to the data-memory port.
  - Store: the value is read through an RF read port and written to memory.
  - Load: the value is read from memory and written through the RF write port.
- Sits between the decode/execute stage and the data-memory interface. Executes LDM/STM-style instructions while the core stalls on busy_o.

Parameters:
- N, 32, data and address width in bits.
- STRIDE, 4, byte increment between consecutive transfer addresses.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- start_i  input  1  launch a transfer; sampled only in IDLE
- is_load_i  input  1  1 = memory to registers, 0 = registers to memory; captured with start_i
- reg_list_i  input  16  bit k set = register k transfers; captured with start_i
- base_addr_i  input  N  address of the first transfer; captured with start_i
- rf_read_addr_o  output  4  RF read port address (store data)
- rf_read_data_i  input  N  RF read port data; combinational from rf_read_addr_o
- rf_write_addr_o  output  4  RF write port address
- rf_write_data_o  output  N  RF write port data
- rf_write_enable_o  output  1  RF write strobe; the RF writes on the clk edge where this is high
- mem_req_o  output  1  memory request valid
- mem_we_o  output  1  1 = write request
- mem_addr_o  output  N  request address
- mem_wdata_o  output  N  write data
- mem_rdata_i  input  N  read data; valid in the mem_ack_i cycle
- mem_ack_i  input  1  request completes this cycle
- busy_o  output  1  sequencer not in IDLE/DONE
- done_o  output  1  one-cycle completion pulse

Behaviour:
- States: IDLE, XFER, WB (only with the optional feature), DONE.
- Reset:
  - State goes to IDLE; the captured mask, address and direction clear to 0.
  - All outputs read 0, including rf_write_enable_o and mem_req_o.
  - Reset in any state aborts the operation. No RF write occurs on the reset edge.
- IDLE:
  - start_i=1 captures the operands. If reg_list_i!=0 go to XFER, else go to DONE.
  - start_i is ignored in every state other than IDLE.
- XFER:
  - cur = index of the lowest set bit of the remaining mask.
  - mem_req_o=1, mem_we_o=~load, mem_addr_o=current address.
  - rf_read_addr_o=cur; mem_wdata_o=rf_read_data_i combinationally.
  - mem_req_o and all request fields stay stable until mem_ack_i.
- On an XFER cycle with mem_ack_i=1:
  - Load: rf_write_enable_o=1, rf_write_addr_o=cur, rf_write_data_o=mem_rdata_i, all in the same cycle.
  - Clear bit cur from the mask; address += STRIDE.
  - If the mask becomes 0, go to DONE (or WB); otherwise stay in XFER for the next register.
- Throughput: one register per cycle when mem_ack_i is high every cycle.
- Latency: start in cycle T, first request in T+1, done_o in cycle T+1+k+waits for k registers.
- DONE: done_o=1 and busy_o=0 for exactly one cycle, then IDLE. An empty list gives done_o in T+1.
- rf_write_enable_o is 0 in every cycle except load-ack cycles (and the WB cycle).
- Address arithmetic is modulo 2^N; wrap-around is permitted, not flagged.
- Register order is always ascending index. Register 15 is an ordinary entry.
- mem_ack_i outside XFER is ignored.
- In cycles where the RF port is unused, rf_write_addr_o and rf_write_data_o read 0.

Optional Feature:
- Macro: BLOCK_TRANSFER_WB_EN.
- Enabled:
  - Adds ports writeback_i (1 bit) and base_reg_i (4 bits), both captured with start_i.
  - If writeback_i=1, the last ack goes to WB instead of DONE.
  - WB is one cycle: rf_write_enable_o=1, rf_write_addr_o=base_reg_i, rf_write_data_o=final address (base+STRIDE*popcount), busy_o=1. Then DONE.
  - Load with the base_reg_i bit set in the list: WB is skipped (the loaded value wins).
  - Empty list with writeback: WB writes the base unchanged.
- Disabled: no WB state and no extra ports; behaviour is exactly as described above.

Test Plan:
- Store, list 0x0005, base 0x100, ack every cycle, RF r0=0xA, r2=0xB -> writes (0x100,0xA) then (0x104,0xB); done_o in T+3; rf_write_enable_o never high.
- Load, list 0x8001, base 0x200, mem returns 0x11 then 0x22, ack delayed 2 cycles per request -> r0=0x11, r15=0x22; mem_req_o and mem_addr_o stable through the waits; done_o at T+7.
- List 0x0000 -> no mem_req_o; done_o in T+1; busy_o never high.
- start_i pulsed during XFER of list 0x00F0 -> ignored; exactly 4 transfers at base+0..+12.
- Base 0xFFFFFFFC, list 0x0003 store -> addresses 0xFFFFFFFC then 0x00000000.
- rst asserted on the second ack of a load, list 0x0007 -> no RF write at that edge; next cycle all outputs 0 and IDLE; a new start then runs normally.
- (With BLOCK_TRANSFER_WB_EN) load, list 0x0006, base 0x40, writeback_i=1, base_reg_i=1 -> r1 loaded, r2 loaded, no WB write. Same with base_reg_i=3 -> WB writes r3=0x48.
